// File: rtl/random_pkg.sv
// random_pkg: shared constants and helpers for the multi-channel LFSR source.
//   GOLDEN      - per-channel seed spreading constant
//   lfsr_taps   - maximal-length right-shift Galois tap mask for widths 8..32
//   seed_derive - channel seed from a base seed and channel index (never zero)
package random_pkg;

    localparam logic [31:0] GOLDEN = 32'h9E37_79B9;

    // Tap mask for next = (s >> 1) ^ (s[0] ? taps : 0); returns 0 if unsupported.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_B400;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

    // seed_i = base ^ (GOLDEN * idx), truncated to width; zero maps to 1.
    function automatic logic [31:0] seed_derive(input logic [31:0]   base,
                                                input int unsigned   idx,
                                                input int unsigned   width);
        logic [31:0] mask;
        logic [31:0] s;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
        s    = (base ^ (GOLDEN * idx)) & mask;
        if (s == 32'h0) begin
            s = 32'h1;
        end
        return s;
    endfunction

endpackage

// File: rtl/random_multi_if.sv
// random_multi_if: control and output bundle of random_multi.
//   en, mode, seed_load, seed : controls driven by the master
//   leds, rnd, valid          : registered outputs driven by the slave
interface random_multi_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4
);
    logic                en;
    logic                mode;
    logic                seed_load;
    logic [WIDTH-1:0]    seed;
    logic [CHANNELS-1:0] leds;
    logic [WIDTH-1:0]    rnd;
    logic                valid;

    modport master (
        output en, mode, seed_load, seed,
        input  leds, rnd, valid
    );

    modport slave (
        input  en, mode, seed_load, seed,
        output leds, rnd, valid
    );
endinterface

// File: rtl/random_multi_lfsr_galois.sv
// lfsr_galois: one right-shift Galois LFSR channel.
//   clk, rst  - clock, synchronous active-high reset (loads RST_VAL)
//   load      - load load_val (beats step)
//   load_val  - value for load
//   step      - advance one position
//   state     - current register contents
module lfsr_galois #(
    parameter int unsigned      WIDTH   = 16,
    parameter logic [WIDTH-1:0] TAPS    = WIDTH'(32'h0000_B400),
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(32'h0000_0001)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] nxt;

    assign state = s_q;

    // Next value is computed from the visible state; an all-zero state
    // (only reachable via an upset) recovers to 1 instead of locking up.
    always_comb begin
        nxt = (state >> 1) ^ (state[0] ? TAPS : '0);
        if (state == '0) begin
            nxt = WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= RST_VAL;
        end else if (load) begin
            s_q <= load_val;
        end else if (step) begin
            s_q <= nxt;
        end
    end

endmodule

// File: rtl/random_multi.sv
// random_multi: CHANNELS independent Galois LFSRs sharing a prescaler.
//   clk   - system clock
//   rst   - synchronous active-high reset
//   bus   - random_multi_if.slave:
//           en (advance enable), mode (0 tick / 1 every cycle),
//           seed_load + seed (reseed all channels),
//           leds (MSB per channel), rnd (channel 0 state),
//           valid (state advanced on the previous edge)
module random_multi
    import random_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      CHANNELS = 4,
    parameter int unsigned      DIV      = 25_000_000,
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(32'h0000_ACE1)
) (
    input logic           clk,
    input logic           rst,
    random_multi_if.slave bus
);

    localparam int unsigned      CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [WIDTH-1:0] TAPS    = WIDTH'(lfsr_taps(WIDTH));

    // Reject unsupported configurations at elaboration.
    if (WIDTH < 8 || WIDTH > 32) begin : g_bad_width
        $error("random_multi: WIDTH must be within 8..32");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("random_multi: CHANNELS must be within 1..16");
    end
    if (DIV < 1) begin : g_bad_div
        $error("random_multi: DIV must be at least 1");
    end

    logic [CNT_W-1:0]    count;
    logic                tick;
    logic                advance;
    logic                valid;
    logic [WIDTH-1:0]    state [CHANNELS];
    logic [CHANNELS-1:0] leds;

    assign tick    = (count == CNT_MAX);
    assign advance = bus.en & (bus.mode | tick);

    // Prescaler free-runs regardless of en; reseed restarts the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            valid <= 1'b0;
        end else if (bus.seed_load) begin
            count <= '0;
            valid <= 1'b0;
        end else begin
            count <= tick ? '0 : count + CNT_W'(1);
            valid <= advance;
        end
    end

    // One LFSR per channel; reseed takes priority over advance inside each.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(seed_derive(32'(SEED), i, WIDTH));

        logic [WIDTH-1:0] load_val;

        assign load_val = WIDTH'(seed_derive(32'(bus.seed), i, WIDTH));

        lfsr_galois #(
            .WIDTH  (WIDTH),
            .TAPS   (TAPS),
            .RST_VAL(RST_VAL)
        ) u_lfsr (
            .clk     (clk),
            .rst     (rst),
            .load    (bus.seed_load),
            .load_val(load_val),
            .step    (advance),
            .state   (state[i])
        );

        assign leds[i] = state[i][WIDTH-1];
    end

    assign bus.leds  = leds;
    assign bus.rnd   = state[0];
    assign bus.valid = valid;

endmodule
